fetch_branch_unit: RTL and testbench

- Upstream neighbour of the single-cycle datapath.
- Holds the PC and fetches 32-bit instructions over a req/ready instruction-memory port.
- Presents each instruction with its PC to decode through a one-entry output register (valid/ready handshake).
- Keeps the NZVC flag register loaded from the ALU flags and resolves B, BL, BR, CBZ and B.cond redirects.

---
 rtl/fetch_branch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_branch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
//   Holds the program counter and fetches 32-bit instruction words over a
//   req/ready instruction-memory port. Each fetched word is presented with its
//   PC to decode through a one-entry output register (valid/ready). Keeps the
//   NZVC flag register and resolves B, BL, BR, CBZ and B.cond redirects.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and address (address stable until ready)
//   imem_ready/rdata  : completes the outstanding request, returns the word
//   instr_valid/ready : output register handshake to decode
//   instr, instr_pc   : instruction word and its PC
//   set_flags, alu_*  : load NZVC from the ALU
//   br_*              : branch resolution (type bits, cc, offsets, BR target)
//   cbz_zero          : CBZ operand is zero
//   flags             : registered {N,Z,V,C}
//   redirect          : taken branch this cycle (combinational)
module fetch_branch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              set_flags,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              br_uncond,
    input  logic              br_cbz,
    input  logic              br_cond,
    input  logic              br_reg,
    input  logic [3:0]        br_cc,
    input  logic [25:0]       br_imm26,
    input  logic [18:0]       br_imm19,
    input  logic [ADDR_W-1:0] br_reg_addr,
    input  logic              cbz_zero,
    output logic [3:0]        flags,
    output logic              redirect
);

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] flush_addr;
    logic [ADDR_W-1:0] target;
    logic [3:0]        eval_flags;
    logic              taken;
    logic              capture;

    // Word offsets scaled to bytes and sign-extended to the address width.
    function automatic logic [ADDR_W-1:0] off26(input logic [25:0] imm);
        return {{(ADDR_W-28){imm[25]}}, imm, 2'b00};
    endfunction

    function automatic logic [ADDR_W-1:0] off19(input logic [18:0] imm);
        return {{(ADDR_W-21){imm[18]}}, imm, 2'b00};
    endfunction

    // nzvc = {N,Z,V,C}
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzvc);
        logic n, z, v, c;
        logic res;
        n = nzvc[3];
        z = nzvc[2];
        v = nzvc[1];
        c = nzvc[0];
        case (cc)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = c;
            4'h3:    res = !c;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = c && !z;
            4'h9:    res = !(c && !z);
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z && (n == v);
            4'hD:    res = !(!z && (n == v));
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // A B.cond resolved alongside a flag-setting instruction sees the new flags.
    assign eval_flags = set_flags ? {alu_negative, alu_zero, alu_overflow, alu_carry} : flags;

    always_comb begin
        taken  = 1'b0;
        target = br_reg_addr;
        if (br_reg) begin
            taken  = 1'b1;
            target = br_reg_addr;
        end else if (br_uncond) begin
            taken  = 1'b1;
            target = br_pc + off26(br_imm26);
        end else if (br_cbz) begin
            taken  = cbz_zero;
            target = br_pc + off19(br_imm19);
        end else if (br_cond) begin
            taken  = cond_pass(br_cc, eval_flags);
            target = br_pc + off19(br_imm19);
        end
    end

    assign redirect = br_valid && taken;

    // In FLUSH the stale request must still be completed, so it stays asserted
    // regardless of decode back-pressure. Gated by reset so nothing is requested
    // while the block is held in reset.
    assign imem_req  = reset && ((state == FLUSH) ||
                                 ((state == FETCH) && (!instr_valid || instr_ready)));
    assign imem_addr = (state == FLUSH) ? flush_addr : fetch_pc;
    assign capture   = imem_req && imem_ready && (state == FETCH) && !redirect;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (redirect && imem_req && !imem_ready) state_nxt = FLUSH;
            FLUSH: if (imem_ready) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            flags       <= '0;
        end else begin
            state <= state_nxt;

            if (set_flags) flags <= {alu_negative, alu_zero, alu_overflow, alu_carry};

            if (redirect)     fetch_pc <= target;
            else if (capture) fetch_pc <= fetch_pc + ADDR_W'(4);

            if (redirect)         instr_valid <= 1'b0;
            else if (capture)     instr_valid <= 1'b1;
            else if (instr_ready) instr_valid <= 1'b0;

            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= fetch_pc;
            end
        end
    end

    // ---- flush address: the outstanding request's address, frozen on entry ----
    always_ff @(posedge clk) begin
        if ((state == FETCH) && (state_nxt == FLUSH)) flush_addr <= fetch_pc;
    end

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              set_flags;
    logic              alu_negative, alu_zero, alu_overflow, alu_carry;
    logic              br_valid;
    logic [ADDR_W-1:0] br_pc;
    logic              br_uncond, br_cbz, br_cond, br_reg;
    logic [3:0]        br_cc;
    logic [25:0]       br_imm26;
    logic [18:0]       br_imm19;
    logic [ADDR_W-1:0] br_reg_addr;
    logic              cbz_zero;
    logic [3:0]        flags;
    logic              redirect;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    logic [ADDR_W-1:0] exp_q[$];

    fetch_branch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .set_flags(set_flags),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .br_valid(br_valid), .br_pc(br_pc),
        .br_uncond(br_uncond), .br_cbz(br_cbz), .br_cond(br_cond), .br_reg(br_reg),
        .br_cc(br_cc), .br_imm26(br_imm26), .br_imm19(br_imm19),
        .br_reg_addr(br_reg_addr), .cbz_zero(cbz_zero),
        .flags(flags), .redirect(redirect)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: answers a request after mem_lat waiting cycles.
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ready = 1'b1;
                    imem_rdata = word_of(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ready = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    // Monitor: every instruction handed to decode is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", instr_pc, '1);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", {32'h0, instr}, {32'h0, word_of(e)});
                end
            end
        end
    end

    // Expect n sequential instructions from pc0, let decode take them, then stall.
    task automatic consume(input int n, input logic [ADDR_W-1:0] pc0, output int cyc);
        for (int i = 0; i < n; i++) exp_q.push_back(pc0 + ADDR_W'(4 * i));
        instr_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        instr_ready = 1'b0;
        if (exp_q.size() != 0) check("consume_timeout", ADDR_W'(exp_q.size()), '0);
    endtask

    task automatic clr_br();
        br_valid = 0; br_uncond = 0; br_cbz = 0; br_cond = 0; br_reg = 0;
        set_flags = 0; cbz_zero = 0;
    endtask

    // typ = {reg, uncond, cbz, cond}
    task automatic set_br(input logic [3:0] typ, input logic [ADDR_W-1:0] pc,
                          input logic [3:0] cc, input logic [25:0] i26,
                          input logic [18:0] i19, input logic [ADDR_W-1:0] ra);
        br_valid = 1; br_reg = typ[3]; br_uncond = typ[2]; br_cbz = typ[1]; br_cond = typ[0];
        br_pc = pc; br_cc = cc; br_imm26 = i26; br_imm19 = i19; br_reg_addr = ra;
    endtask

    task automatic set_alu(input logic [3:0] nzvc, input logic ld);
        {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
        set_flags = ld;
    endtask

    // Combinational taken check within one cycle; nothing reaches a clock edge.
    task automatic cond_vec(input string name, input logic [3:0] nzvc, input logic [3:0] cc,
                            input logic [3:0] typ, input logic cz, input logic exp);
        @(posedge clk); #1;
        set_alu(nzvc, 1'b1);
        cbz_zero = cz;
        set_br(typ, 64'h100, cc, 26'd0, 19'd0, 64'h200);
        #1;
        check(name, {63'h0, redirect}, {63'h0, exp});
        clr_br();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 0; instr_ready = 0;
        set_alu(4'h0, 1'b0);
        br_pc = '0; br_cc = '0; br_imm26 = '0; br_imm19 = '0; br_reg_addr = '0;
        clr_br();

        // ---- 1: reset state, then streaming at one instruction per cycle ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_valid", {63'h0, instr_valid}, 0);
        check("rst_imem_req", {63'h0, imem_req}, 0);
        check("rst_flags", {60'h0, flags}, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_instr", {32'h0, instr}, 0);
        reset = 1;
        #1;
        check("first_req", {63'h0, imem_req}, 1);
        check("first_addr", imem_addr, 64'h0);
        consume(4, 64'h0, cyc);
        check("stream_cycles", ADDR_W'(cyc), 5);

        // ---- 2: memory wait states and decode stall ----
        mem_lat = 3;
        consume(1, 64'h10, cyc);
        for (int k = 0; k < 3; k++) begin
            check("wait_req", {63'h0, imem_req}, 1);
            check("wait_addr", imem_addr, 64'h14);
            check("wait_valid", {63'h0, instr_valid}, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            check("stall_valid", {63'h0, instr_valid}, 1);
            check("stall_pc", instr_pc, 64'h14);
            check("stall_no_req", {63'h0, imem_req}, 0);
            @(posedge clk); #1;
        end
        consume(2, 64'h14, cyc);
        repeat (6) @(posedge clk);
        #1;
        check("held_28", instr_pc, 64'h1C);
        mem_lat = 0;

        // ---- 3: flags and B.cond, registered and bypassed ----
        set_alu(4'b1000, 1'b1);
        @(posedge clk); #1;
        clr_br();
        check("flags_n", {60'h0, flags}, 64'h8);
        set_br(4'b0001, 64'h40, 4'hB, 26'd0, 19'h7FFFC, 64'h0);
        #1;
        check("lt_taken", {63'h0, redirect}, 1);
        @(posedge clk); #1;
        clr_br();
        check("lt_target", imem_addr, 64'h30);
        check("lt_kill", {63'h0, instr_valid}, 0);
        consume(2, 64'h30, cyc);
        set_br(4'b0001, 64'h40, 4'hA, 26'd0, 19'h7FFFC, 64'h0);
        #1;
        check("ge_not_taken", {63'h0, redirect}, 0);
        @(posedge clk); #1;
        clr_br();
        check("ge_hold_pc", instr_pc, 64'h38);
        consume(1, 64'h38, cyc);
        set_alu(4'b0000, 1'b1);
        set_br(4'b0001, 64'h40, 4'hA, 26'd0, 19'h7FFFC, 64'h0);
        #1;
        check("bypass_taken", {63'h0, redirect}, 1);
        @(posedge clk); #1;
        clr_br();
        check("bypass_flags", {60'h0, flags}, 0);
        check("bypass_target", imem_addr, 64'h30);
        consume(1, 64'h30, cyc);
        set_alu(4'b1000, 1'b1);
        set_br(4'b0001, 64'h40, 4'hA, 26'd0, 19'h7FFFC, 64'h0);
        #1;
        check("bypass_not_taken", {63'h0, redirect}, 0);
        @(posedge clk); #1;
        clr_br();
        check("bypass_hold_pc", instr_pc, 64'h34);

        cond_vec("cc_eq", 4'b0100, 4'h0, 4'b0001, 0, 1);
        cond_vec("cc_ne", 4'b0100, 4'h1, 4'b0001, 0, 0);
        cond_vec("cc_hs", 4'b0001, 4'h2, 4'b0001, 0, 1);
        cond_vec("cc_lo", 4'b0001, 4'h3, 4'b0001, 0, 0);
        cond_vec("cc_mi", 4'b1000, 4'h4, 4'b0001, 0, 1);
        cond_vec("cc_pl", 4'b1000, 4'h5, 4'b0001, 0, 0);
        cond_vec("cc_vs", 4'b0010, 4'h6, 4'b0001, 0, 1);
        cond_vec("cc_vc", 4'b0000, 4'h7, 4'b0001, 0, 1);
        cond_vec("cc_hi", 4'b0001, 4'h8, 4'b0001, 0, 1);
        cond_vec("cc_hi_z", 4'b0101, 4'h8, 4'b0001, 0, 0);
        cond_vec("cc_ls", 4'b0101, 4'h9, 4'b0001, 0, 1);
        cond_vec("cc_ge", 4'b1010, 4'hA, 4'b0001, 0, 1);
        cond_vec("cc_lt", 4'b1000, 4'hB, 4'b0001, 0, 1);
        cond_vec("cc_gt", 4'b0000, 4'hC, 4'b0001, 0, 1);
        cond_vec("cc_gt_z", 4'b0100, 4'hC, 4'b0001, 0, 0);
        cond_vec("cc_le", 4'b0100, 4'hD, 4'b0001, 0, 1);
        cond_vec("cc_al", 4'b0000, 4'hE, 4'b0001, 0, 1);
        cond_vec("cbz_zero", 4'b0000, 4'h0, 4'b0010, 1, 1);
        cond_vec("cbz_nonzero", 4'b0100, 4'h0, 4'b0010, 0, 0);
        cond_vec("prio_reg_cond", 4'b0000, 4'h0, 4'b1001, 0, 1);
        cond_vec("prio_cbz_cond", 4'b0000, 4'hE, 4'b0011, 0, 0);
        cond_vec("no_type", 4'b0000, 4'hE, 4'b0000, 1, 0);
        consume(1, 64'h34, cyc);

        // ---- 4: B wrap-around target, BR target with priority ----
        set_br(4'b0100, 64'h0, 4'h0, 26'h3FFFFFF, 19'd0, 64'h0);
        @(posedge clk); #1;
        clr_br();
        check("b_wrap", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        consume(1, 64'hFFFF_FFFF_FFFF_FFFC, cyc);
        check("wrap_next_pc", instr_pc, 64'h0);
        set_br(4'b1100, 64'h0, 4'h0, 26'd1, 19'd0, 64'h1000);
        @(posedge clk); #1;
        clr_br();
        check("br_target", imem_addr, 64'h1000);
        consume(1, 64'h1000, cyc);

        // ---- 5: redirect with a request outstanding ----
        mem_lat = 3;
        consume(1, 64'h1004, cyc);
        set_br(4'b0100, 64'h2000, 4'h0, 26'd1, 19'd0, 64'h0);
        #1;
        check("pend_redirect", {63'h0, redirect}, 1);
        check("pend_req", {63'h0, imem_req}, 1);
        @(posedge clk); #1;
        clr_br();
        check("flush_addr0", imem_addr, 64'h1008);
        check("flush_valid0", {63'h0, instr_valid}, 0);
        set_br(4'b1000, 64'h0, 4'h0, 26'd0, 19'd0, 64'h3000);
        #1;
        check("flush_redirect", {63'h0, redirect}, 1);
        @(posedge clk); #1;
        clr_br();
        check("flush_addr1", imem_addr, 64'h1008);
        check("flush_req1", {63'h0, imem_req}, 1);
        @(posedge clk); #1;
        check("post_flush_addr", imem_addr, 64'h3000);
        check("post_flush_valid", {63'h0, instr_valid}, 0);
        consume(1, 64'h3000, cyc);
        cyc = 0;
        while (!instr_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("refill_valid", {63'h0, instr_valid}, 1);
        check("refill_pc", instr_pc, 64'h3004);

        // ---- 6: asynchronous reset in the middle of a request ----
        @(posedge clk); #1;
        instr_ready = 1'b1;
        #1;
        reset = 0;
        #1;
        instr_ready = 1'b0;
        check("areset_valid", {63'h0, instr_valid}, 0);
        check("areset_flags", {60'h0, flags}, 0);
        check("areset_req", {63'h0, imem_req}, 0);
        mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check("rerun_req", {63'h0, imem_req}, 1);
        check("rerun_addr", imem_addr, 64'h0);
        consume(1, 64'h0, cyc);
        check("queue_empty", ADDR_W'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
